seq_uart_tx: RTL and testbench

Serial transmitter that sits directly downstream of the sequencer. It consumes the sequencer's send-byte interface (tx data, tx valid) and returns tx busy as backpressure. Each accepted byte is serialized onto a single UART line as 8N1, LSB first, at a fixed baud rate derived from the system clock. A parity bit can be added at compile time.

---
 rtl/seq_uart_tx_if.sv | 25 ++
 rtl/seq_uart_tx.sv | 143 ++++++++++++++
 tb/tb_seq_uart_tx.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/seq_uart_tx_if.sv
// Send-byte handshake between the sequencer (master) and the UART transmitter (slave).
// Carries the byte/request pair, the busy backpressure and the serial line itself.
`timescale 1ns/1ps
interface seq_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] i_tx_data;
  logic                  i_tx_valid;
  logic                  o_tx_busy;
  logic                  o_txd;

  modport master (
    output i_tx_data,
    output i_tx_valid,
    input  o_tx_busy,
    input  o_txd
  );

  modport slave (
    input  i_tx_data,
    input  i_tx_valid,
    output o_tx_busy,
    output o_txd
  );
endinterface

// File: rtl/seq_uart_tx.sv
// 8N1 UART transmitter, LSB first, fed by the sequencer send-byte handshake.
// Define SEQ_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
`timescale 1ns/1ps
module seq_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_WIDTH    = 10
) (
  input  logic          clk,
  input  logic          rst,
  seq_uart_tx_if.slave  tx
);

  localparam int IDX_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef SEQ_UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t                  state_reg, state_next;
  logic [CNT_WIDTH-1:0]    cnt_reg, cnt_next;
  logic [IDX_WIDTH-1:0]    idx_reg, idx_next;
  logic [DATA_WIDTH-1:0]   shift_reg, shift_next;
  logic                    txd_reg, txd_next;
  logic                    busy_reg, busy_next;
  logic                    bit_done;
`ifdef SEQ_UART_TX_PARITY_EN
  logic                    parity_reg, parity_next;
`endif

  assign bit_done = (cnt_reg == CNT_LAST);

  // Outputs are computed one cycle ahead so the line and busy come straight from flops.
  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    txd_next   = txd_reg;
    busy_next  = busy_reg;
`ifdef SEQ_UART_TX_PARITY_EN
    parity_next = parity_reg;
`endif
    if (state_reg != ST_IDLE && !bit_done) begin
      cnt_next = cnt_reg + CNT_WIDTH'(1);
    end

    case (state_reg)
      ST_IDLE: begin
        if (tx.i_tx_valid && !busy_reg) begin
          shift_next = tx.i_tx_data;
`ifdef SEQ_UART_TX_PARITY_EN
          parity_next = ^tx.i_tx_data;
`endif
          idx_next   = '0;
          txd_next   = 1'b0;
          busy_next  = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          txd_next   = shift_reg[0];
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (idx_reg == IDX_LAST) begin
`ifdef SEQ_UART_TX_PARITY_EN
            txd_next   = parity_reg;
            state_next = ST_PARITY;
`else
            txd_next   = 1'b1;
            state_next = ST_STOP;
`endif
          end else begin
            // Next bit is shift_reg[1] before the shift lands.
            idx_next   = idx_reg + IDX_WIDTH'(1);
            shift_next = {1'b0, shift_reg[DATA_WIDTH-1:1]};
            txd_next   = shift_reg[1];
          end
        end
      end
`ifdef SEQ_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) begin
          txd_next   = 1'b1;
          state_next = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_done) begin
          txd_next   = 1'b1;
          busy_next  = 1'b0;
          state_next = ST_IDLE;
        end
      end
      default: begin
        txd_next   = 1'b1;
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      txd_reg   <= 1'b1;
      busy_reg  <= 1'b0;
`ifdef SEQ_UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      txd_reg   <= txd_next;
      busy_reg  <= busy_next;
`ifdef SEQ_UART_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  assign tx.o_txd     = txd_reg;
  assign tx.o_tx_busy = busy_reg;

endmodule

// File: tb/tb_seq_uart_tx.sv
// Directed bench for seq_uart_tx at CLKS_PER_BIT=4: table of frames plus reset,
// backpressure, stop-bit collision and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_seq_uart_tx;
  localparam int N  = 4;
  localparam int DW = 8;
`ifdef SEQ_UART_TX_PARITY_EN
  localparam int SLOTS = 11;
  // Expected line per slot, bit k = slot k: {stop, parity, data[7:0], start}
  localparam logic [10:0] L_A5 = 11'b1_0_10100101_0;
  localparam logic [10:0] L_00 = 11'b1_0_00000000_0;
  localparam logic [10:0] L_FF = 11'b1_0_11111111_0;
  localparam logic [10:0] L_07 = 11'b1_1_00000111_0;
  localparam logic [10:0] L_03 = 11'b1_0_00000011_0;
  localparam logic [10:0] L_3C = 11'b1_0_00111100_0;
  localparam logic [10:0] L_55 = 11'b1_0_01010101_0;
`else
  localparam int SLOTS = 10;
  // Expected line per slot, bit k = slot k: {stop, data[7:0], start}
  localparam logic [10:0] L_A5 = 11'b0_1_10100101_0;
  localparam logic [10:0] L_00 = 11'b0_1_00000000_0;
  localparam logic [10:0] L_FF = 11'b0_1_11111111_0;
  localparam logic [10:0] L_07 = 11'b0_1_00000111_0;
  localparam logic [10:0] L_03 = 11'b0_1_00000011_0;
  localparam logic [10:0] L_3C = 11'b0_1_00111100_0;
  localparam logic [10:0] L_55 = 11'b0_1_01010101_0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_uart_tx_if #(.DATA_WIDTH(DW)) tx_bus ();

  seq_uart_tx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(N),
    .CNT_WIDTH   (10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx (tx_bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] line;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input int cyc, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, got, exp);
    end
  endtask

  // Present a byte at a negedge, then check every cycle of the frame and the idle cycle after it.
  task automatic send_frame(input logic [7:0] d, input logic [10:0] line, input bit hold,
                            input logic [7:0] mid_d, input bit pulse_last);
    int e0;
    e0 = errors;
    tx_bus.i_tx_data  = d;
    tx_bus.i_tx_valid = 1'b1;
    @(negedge clk);
    if (!hold) tx_bus.i_tx_valid = 1'b0;
    for (int c = 1; c <= SLOTS * N; c++) begin
      check("busy", c, tx_bus.o_tx_busy, 1'b1);
      check("txd", c, tx_bus.o_txd, line[(c - 1) / N]);
      if (hold && c == (SLOTS * N) / 2) tx_bus.i_tx_data = mid_d;
      if (pulse_last && c == SLOTS * N) tx_bus.i_tx_valid = 1'b1;
      @(negedge clk);
    end
    if (pulse_last) tx_bus.i_tx_valid = 1'b0;
    check("idle_busy", SLOTS * N + 1, tx_bus.o_tx_busy, 1'b0);
    check("idle_txd", SLOTS * N + 1, tx_bus.o_txd, 1'b1);
    $display("frame data=%h slots=%0d new_errors=%0d", d, SLOTS, errors - e0);
  endtask

  initial begin
    vecs[0] = '{8'hA5, L_A5};
    vecs[1] = '{8'h00, L_00};
    vecs[2] = '{8'hFF, L_FF};
    vecs[3] = '{8'h07, L_07};
    vecs[4] = '{8'h03, L_03};

    // Reset held with a pending request: no frame may start.
    rst = 1'b0;
    tx_bus.i_tx_valid = 1'b1;
    tx_bus.i_tx_data  = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_busy", i, tx_bus.o_tx_busy, 1'b0);
      check("rst_txd", i, tx_bus.o_txd, 1'b1);
    end
    $display("reset hold done errors=%0d", errors);
    rst = 1'b1;

    // First entry is accepted on the first edge after release; the rest run back-to-back.
    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].data, vecs[i].line, 1'b0, 8'h00, 1'b0);
    end

    // Backpressure: data changes mid-frame while valid stays high.
    send_frame(8'h3C, L_3C, 1'b1, 8'hFF, 1'b0);
    send_frame(8'hFF, L_FF, 1'b0, 8'h00, 1'b0);

    // Request only during the final stop cycle is not an accept.
    send_frame(8'h00, L_00, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("nocollide_busy", i, tx_bus.o_tx_busy, 1'b0);
      check("nocollide_txd", i, tx_bus.o_txd, 1'b1);
    end
    $display("stop-bit collision done errors=%0d", errors);

    // Reset during data bit 3 of 0x55.
    tx_bus.i_tx_data  = 8'h55;
    tx_bus.i_tx_valid = 1'b1;
    @(negedge clk);
    tx_bus.i_tx_valid = 1'b0;
    repeat (4 * N + 1) @(negedge clk);
    check("bit3_txd", 0, tx_bus.o_txd, 1'b0);
    check("bit3_busy", 0, tx_bus.o_tx_busy, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_txd", 0, tx_bus.o_txd, 1'b1);
    check("midrst_busy", 0, tx_bus.o_tx_busy, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("postrst_txd", 0, tx_bus.o_txd, 1'b1);
    check("postrst_busy", 0, tx_bus.o_tx_busy, 1'b0);
    $display("mid-frame reset done errors=%0d", errors);
    send_frame(8'h55, L_55, 1'b0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
